// File: rtl/cond_wait_unit_if.sv
// cond_wait_unit_if: arm request, live conditions and result handshake.
// master drives arm_*/cond/cancel/done_ready; slave (the unit) drives the rest.
interface cond_wait_unit_if #(
  parameter int N_COND = 4,
  parameter int TMO_W  = 16
);
  localparam int IDX_W = (N_COND > 1) ? $clog2(N_COND) : 1;

  logic              arm_valid;
  logic              arm_ready;
  logic [N_COND-1:0] arm_mask;
  logic              arm_all;
  logic [TMO_W-1:0]  arm_timeout;
`ifdef COND_WAIT_EDGE_EN
  logic              arm_edge;
`endif
  logic [N_COND-1:0] cond;
  logic              cancel;
  logic              done_valid;
  logic              done_ready;
  logic [N_COND-1:0] done_hit;
  logic [IDX_W-1:0]  done_which;
  logic              done_timeout;
  logic [TMO_W-1:0]  wait_cycles;
  logic              busy;

  modport master (
`ifdef COND_WAIT_EDGE_EN
    output arm_edge,
`endif
    output arm_valid, arm_mask, arm_all,
    output arm_timeout, cond, cancel,
    output done_ready,
    input  arm_ready, done_valid, done_hit,
    input  done_which, done_timeout,
    input  wait_cycles, busy
  );

  modport slave (
`ifdef COND_WAIT_EDGE_EN
    input  arm_edge,
`endif
    input  arm_valid, arm_mask, arm_all,
    input  arm_timeout, cond, cancel,
    input  done_ready,
    output arm_ready, done_valid, done_hit,
    output done_which, done_timeout,
    output wait_cycles, busy
  );
endinterface

// File: rtl/cond_wait_unit.sv
// cond_wait_unit: waits for any/all masked conditions or a cycle timeout.
// Ports: clk, rst (async high), bus (slave). `COND_WAIT_EDGE_EN adds arm_edge.
module cond_wait_unit #(
  parameter int N_COND = 4,
  parameter int TMO_W  = 16,
  localparam int IDX_W =
    (N_COND > 1) ? $clog2(N_COND) : 1
) (
  input logic clk,
  input logic rst,
  cond_wait_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_COND-1:0] mask_q, mask_d;
  logic              all_q, all_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [N_COND-1:0] hit_q, hit_d;
  logic [IDX_W-1:0]  which_q, which_d;
  logic              dto_q, dto_d;
  logic [TMO_W-1:0]  wcyc_q, wcyc_d;

  logic [N_COND-1:0] live;
  logic              sat;
  logic [TMO_W-1:0]  cnt_inc;
  logic              tmo_hit;

`ifdef COND_WAIT_EDGE_EN
  logic              edge_q, edge_d;
  logic [N_COND-1:0] prev_q, prev_d;
  logic [N_COND-1:0] seen_q, seen_d;
  logic [N_COND-1:0] rise;
`endif

  function automatic logic [IDX_W-1:0] low_idx(
    input logic [N_COND-1:0] v
  );
    low_idx = '0;
    for (int i = N_COND - 1; i >= 0; i--)
      if (v[i]) low_idx = IDX_W'(i);
  endfunction

  // Edge mode: rises accumulate in seen_q so AND
  // completes once every masked bit has risen.
  always_comb begin
`ifdef COND_WAIT_EDGE_EN
    rise = bus.cond & ~prev_q & mask_q;
    live = edge_q ? (seen_q | rise)
                  : (bus.cond & mask_q);
`else
    live = bus.cond & mask_q;
`endif
    sat = all_q ? (live == mask_q) : (|live);
    cnt_inc = (&cnt_q) ? cnt_q
                       : cnt_q + TMO_W'(1);
    tmo_hit = (tmo_q != '0) && (cnt_inc == tmo_q);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    all_d   = all_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    which_d = which_q;
    dto_d   = dto_q;
    wcyc_d  = wcyc_q;
`ifdef COND_WAIT_EDGE_EN
    edge_d  = edge_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.arm_valid) begin
          mask_d = bus.arm_mask;
          all_d  = bus.arm_all;
          tmo_d  = bus.arm_timeout;
          cnt_d  = '0;
`ifdef COND_WAIT_EDGE_EN
          edge_d = bus.arm_edge;
          prev_d = bus.cond;
          seen_d = '0;
`endif
          if (bus.arm_mask == '0) begin
            state_d = DONE;
            hit_d   = '0;
            which_d = '0;
            dto_d   = 1'b1;
            wcyc_d  = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
`ifdef COND_WAIT_EDGE_EN
        prev_d = bus.cond;
        seen_d = live;
`endif
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (sat) begin
          state_d = DONE;
          hit_d   = live;
          which_d = low_idx(live);
          dto_d   = 1'b0;
          wcyc_d  = cnt_inc;
        end else if (tmo_hit) begin
          state_d = DONE;
          hit_d   = live;
          which_d = low_idx(live);
          dto_d   = 1'b1;
          wcyc_d  = tmo_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      all_q   <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      which_q <= '0;
      dto_q   <= 1'b0;
      wcyc_q  <= '0;
`ifdef COND_WAIT_EDGE_EN
      edge_q  <= 1'b0;
      prev_q  <= '0;
      seen_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      all_q   <= all_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      which_q <= which_d;
      dto_q   <= dto_d;
      wcyc_q  <= wcyc_d;
`ifdef COND_WAIT_EDGE_EN
      edge_q  <= edge_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
`endif
    end
  end

  assign bus.arm_ready    = (state_q == IDLE);
  assign bus.done_valid   = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done_hit     = hit_q;
  assign bus.done_which   = which_q;
  assign bus.done_timeout = dto_q;
  assign bus.wait_cycles  = wcyc_q;

endmodule

// File: tb/tb_cond_wait_unit.sv
// tb_cond_wait_unit: table of directed waits plus
// hand sequences for cancel, hold, reset and empty mask.
module tb_cond_wait_unit;
  localparam int N  = 4;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_wait_unit_if #(.N_COND(N), .TMO_W(TW)) bus ();
  cond_wait_unit #(.N_COND(N), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  cond_wait_unit_if #(.N_COND(2), .TMO_W(TW)) bus2 ();
  cond_wait_unit #(.N_COND(2), .TMO_W(TW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  mask;
    logic        all;
    logic [15:0] tmo;
    logic [3:0]  c0;
    int          at1;
    logic [3:0]  c1;
    int          at2;
    logic [3:0]  c2;
    logic [3:0]  hit;
    logic [1:0]  which;
    logic        dto;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] cval(input vec_t v,
                                      input int n);
    if (n >= v.at2) return v.c2;
    if (n >= v.at1) return v.c1;
    return v.c0;
  endfunction

  task automatic idle_in();
    bus.arm_valid   = 1'b0;
    bus.arm_mask    = '0;
    bus.arm_all     = 1'b0;
    bus.arm_timeout = '0;
    bus.cond        = '0;
    bus.cancel      = 1'b0;
    bus.done_ready  = 1'b0;
`ifdef COND_WAIT_EDGE_EN
    bus.arm_edge    = 1'b0;
`endif
  endtask

  task automatic arm(input logic [3:0] m,
                     input logic a,
                     input logic [15:0] t);
    bus.arm_valid   = 1'b1;
    bus.arm_mask    = m;
    bus.arm_all     = a;
    bus.arm_timeout = t;
  endtask

  task automatic consume(input string nm);
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    bus.cond = '0;
    chk({nm, "_idle"}, bus.arm_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    bit got;
    arm(v.mask, v.all, v.tmo);
    bus.cond = cval(v, 0);
    @(posedge clk); #1;
    bus.arm_valid = 1'b0;
    chk({nm, "_busy"}, bus.busy, 1);
    chk({nm, "_early"}, bus.done_valid, 0);
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      n++;
      bus.cond = cval(v, n);
      @(posedge clk); #1;
      if (bus.done_valid) got = 1'b1;
    end
    chk({nm, "_done"}, got, 1);
    chk({nm, "_evals"}, n, v.wc);
    chk({nm, "_hit"}, bus.done_hit, v.hit);
    chk({nm, "_which"}, bus.done_which, v.which);
    chk({nm, "_tmo"}, bus.done_timeout, v.dto);
    chk({nm, "_wcyc"}, bus.wait_cycles, v.wc);
    consume(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;

    //        mask  all tmo  c0   at1 c1   at2 c2   hit  wh dto wc
    tbl[0] = '{4'h3, 0, 0, 4'h0, 3, 4'h2, 99, 4'h0,
               4'h2, 1, 0, 3};
    tbl[1] = '{4'h5, 1, 0, 4'h0, 1, 4'h1, 4, 4'h5,
               4'h5, 0, 0, 4};
    tbl[2] = '{4'h1, 0, 5, 4'h0, 99, 4'h0, 99, 4'h0,
               4'h0, 0, 1, 5};
    tbl[3] = '{4'h1, 0, 5, 4'h0, 99, 4'h0, 5, 4'h1,
               4'h1, 0, 0, 5};
    tbl[4] = '{4'h8, 0, 0, 4'h8, 99, 4'h0, 99, 4'h0,
               4'h8, 3, 0, 1};
    tbl[5] = '{4'h6, 1, 3, 4'h0, 1, 4'h2, 99, 4'h0,
               4'h2, 1, 1, 3};
    tbl[6] = '{4'h4, 0, 2, 4'hB, 99, 4'h0, 99, 4'h0,
               4'h0, 0, 1, 2};
    tbl[7] = '{4'hE, 0, 0, 4'h0, 2, 4'hA, 99, 4'h0,
               4'hA, 1, 0, 2};
    tbl[8] = '{4'hF, 1, 0, 4'hF, 99, 4'h0, 99, 4'h0,
               4'hF, 0, 0, 1};
    tbl[9] = '{4'h1, 0, 1, 4'h0, 99, 4'h0, 99, 4'h0,
               4'h0, 0, 1, 1};

    idle_in();
    bus2.arm_valid   = 1'b0;
    bus2.arm_mask    = '0;
    bus2.arm_all     = 1'b0;
    bus2.arm_timeout = '0;
    bus2.cond        = '0;
    bus2.cancel      = 1'b0;
    bus2.done_ready  = 1'b0;
`ifdef COND_WAIT_EDGE_EN
    bus2.arm_edge    = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arm_ready", bus.arm_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done_valid", bus.done_valid, 0);
    chk("rst_hit", bus.done_hit, 0);
    chk("rst_which", bus.done_which, 0);
    chk("rst_tmo", bus.done_timeout, 0);
    chk("rst_wcyc", bus.wait_cycles, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // two-condition instance: cond[1] rises on cycle 3
    bus2.arm_valid = 1'b1;
    bus2.arm_mask  = 2'b11;
    @(posedge clk); #1;
    bus2.arm_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      n++;
      bus2.cond = (n >= 3) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      if (bus2.done_valid) got = 1'b1;
    end
    chk("n2_done", got, 1);
    chk("n2_which", bus2.done_which, 1);
    chk("n2_hit", bus2.done_hit, 2'b10);
    chk("n2_tmo", bus2.done_timeout, 0);
    chk("n2_wcyc", bus2.wait_cycles, 3);
    bus2.done_ready = 1'b1;
    @(posedge clk); #1;
    bus2.done_ready = 1'b0;
    chk("n2_idle", bus2.arm_ready, 1);

    // cancel on WAIT cycle 2 beats a true condition
    arm(4'h1, 1'b0, 16'd0);
    @(posedge clk); #1;
    bus.arm_valid = 1'b0;
    @(posedge clk); #1;
    bus.cancel = 1'b1;
    bus.cond = 4'h1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    bus.cond = 4'h0;
    chk("cancel_ready", bus.arm_ready, 1);
    chk("cancel_busy", bus.busy, 0);
    chk("cancel_done", bus.done_valid, 0);
    @(posedge clk); #1;
    chk("cancel_done2", bus.done_valid, 0);

    // DONE holds while done_ready low
    arm(4'h2, 1'b0, 16'd0);
    bus.cond = 4'h2;
    @(posedge clk); #1;
    bus.arm_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_done", bus.done_valid, 1);
    for (int k = 0; k < 4; k++) begin
      arm(4'h1, 1'b1, 16'd3);
      bus.cancel = 1'b1;
      bus.cond = (k[0]) ? 4'hD : 4'h0;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k),
          bus.done_valid, 1);
      chk($sformatf("hold%0d_ready", k),
          bus.arm_ready, 0);
      chk($sformatf("hold%0d_hit", k),
          bus.done_hit, 4'h2);
      chk($sformatf("hold%0d_which", k),
          bus.done_which, 1);
      chk($sformatf("hold%0d_wcyc", k),
          bus.wait_cycles, 1);
      chk($sformatf("hold%0d_tmo", k),
          bus.done_timeout, 0);
    end
    bus.arm_valid = 1'b0;
    bus.cancel = 1'b0;
    consume("hold");
    chk("hold_released", bus.done_valid, 0);

    // async reset mid-WAIT, checked before any edge
    arm(4'h1, 1'b0, 16'd0);
    @(posedge clk); #1;
    bus.arm_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done_valid, 0);
    chk("arst_ready", bus.arm_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // empty mask goes straight to DONE
    arm(4'h0, 1'b0, 16'd7);
    @(posedge clk); #1;
    bus.arm_valid = 1'b0;
    chk("empty_done", bus.done_valid, 1);
    chk("empty_tmo", bus.done_timeout, 1);
    chk("empty_wcyc", bus.wait_cycles, 0);
    chk("empty_hit", bus.done_hit, 0);
    chk("empty_which", bus.done_which, 0);
    consume("empty");

`ifdef COND_WAIT_EDGE_EN
    // level high at arm must fall and rise again
    bus.arm_edge = 1'b1;
    run_vec('{4'h8, 0, 0, 4'h8, 4, 4'h0, 5, 4'h8,
              4'h8, 3, 0, 5}, "edge_or");
    run_vec('{4'h5, 1, 0, 4'h0, 2, 4'h1, 3, 4'h4,
              4'h5, 0, 0, 3}, "edge_and");
    bus.arm_edge = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
